// File: rtl/ysyx_23060184_lsu_axi_if.sv
// ============================================================================
// Module  : ysyx_23060184_lsu_axi_if
// Brief   : EXU/WBU handshake plus N-slave AXI4-Lite bundle for the LSU
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ysyx_23060184_lsu_axi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLV    = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          mem_read;
    logic                          mem_write;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [1:0]                    size;
    logic                          sign_ext;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [1:0]                    fault;
    logic                          bus_req;
    logic                          bus_grant;
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic [NUM_SLV-1:0]            m_arvalid;
    logic [NUM_SLV-1:0]            m_arready;
    logic [NUM_SLV*DATA_WIDTH-1:0] m_rdata;
    logic [NUM_SLV*2-1:0]          m_rresp;
    logic [NUM_SLV-1:0]            m_rvalid;
    logic                          m_rready;
    logic [ADDR_WIDTH-1:0]         m_awaddr;
    logic [NUM_SLV-1:0]            m_awvalid;
    logic [NUM_SLV-1:0]            m_awready;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic [3:0]                    m_wstrb;
    logic [NUM_SLV-1:0]            m_wvalid;
    logic [NUM_SLV-1:0]            m_wready;
    logic [NUM_SLV*2-1:0]          m_bresp;
    logic [NUM_SLV-1:0]            m_bvalid;
    logic                          m_bready;

    modport master (
        input  in_valid, mem_read, mem_write, addr, wdata, size, sign_ext, out_ready,
        input  bus_grant, m_arready, m_rdata, m_rresp, m_rvalid,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        output in_ready, out_valid, rdata, fault, bus_req,
        output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
        output m_wdata, m_wstrb, m_wvalid, m_bready
    );

    modport slave (
        output in_valid, mem_read, mem_write, addr, wdata, size, sign_ext, out_ready,
        output bus_grant, m_arready, m_rdata, m_rresp, m_rvalid,
        output m_awready, m_wready, m_bresp, m_bvalid,
        input  in_ready, out_valid, rdata, fault, bus_req,
        input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
        input  m_wdata, m_wstrb, m_wvalid, m_bready
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060184_lsu_axi.sv
// ============================================================================
// Module  : ysyx_23060184_lsu_axi
// Brief   : Load/store unit arbitrating for a shared AXI4-Lite bus to N slaves
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060184_lsu_axi #(
    parameter int                              DATA_WIDTH = 32,
    parameter int                              ADDR_WIDTH = 32,
    parameter int                              NUM_SLV    = 2,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_BASE   = {32'ha000_0000, 32'h8000_0000},
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_MASK   = {32'hffff_fff0, 32'hf800_0000}
) (
    input  wire logic                 clk,
    input  wire logic                 rstn,
    ysyx_23060184_lsu_axi_if.master   bus
);
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_AR   = 3'd2,
        S_R    = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic                  r_sext;
    logic                  r_is_load;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_fault;

    logic                  w_accept, w_misal, w_hit;
    logic [SEL_W-1:0]      w_hit_idx;
    logic                  w_arready, w_rvalid, w_awready, w_wready, w_bvalid;
    logic [1:0]            w_rresp, w_bresp;
    logic [DATA_WIDTH-1:0] w_rword, w_load, w_wlane;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [3:0]            w_wstrb;

    // Walk from the top index down so the lowest matching slave wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((bus.addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(i);
            end
        end
    end

    assign w_misal  = (bus.size == 2'b11) ||
                      ((bus.size == 2'b01) && bus.addr[0]) ||
                      ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign w_accept = (r_state == S_IDLE) && bus.in_valid && (bus.mem_read || bus.mem_write);

    assign w_arready = bus.m_arready[r_sel];
    assign w_rvalid  = bus.m_rvalid[r_sel];
    assign w_awready = bus.m_awready[r_sel];
    assign w_wready  = bus.m_wready[r_sel];
    assign w_bvalid  = bus.m_bvalid[r_sel];
    assign w_rresp   = bus.m_rresp[r_sel*2 +: 2];
    assign w_bresp   = bus.m_bresp[r_sel*2 +: 2];
    assign w_rword   = bus.m_rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_byte    = w_rword[{r_addr[1:0], 3'b000} +: 8];
    assign w_half    = w_rword[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_rword;
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = w_rword;
        endcase
    end

    // Narrow stores are replicated across every lane; the strobe picks the live bytes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wlane = r_wdata;
        case (r_size)
            2'b00:   begin w_wstrb = 4'b0001 << r_addr[1:0]; w_wlane = {4{r_wdata[7:0]}};  end
            2'b01:   begin w_wstrb = 4'b0011 << r_addr[1:0]; w_wlane = {2{r_wdata[15:0]}}; end
            default: begin w_wstrb = 4'b1111;                w_wlane = r_wdata;            end
        endcase
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.bus_req   = 1'b0;
        bus.m_arvalid = '0;
        bus.m_rready  = 1'b0;
        bus.m_awvalid = '0;
        bus.m_wvalid  = '0;
        bus.m_bready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (w_accept) w_next = (w_misal || !w_hit) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                bus.bus_req = 1'b1;
                if (bus.bus_grant) w_next = r_is_load ? S_AR : S_W;
            end
            S_AR: begin
                bus.bus_req          = 1'b1;
                bus.m_arvalid[r_sel] = 1'b1;
                if (w_arready) w_next = S_R;
            end
            S_R: begin
                bus.bus_req  = 1'b1;
                bus.m_rready = 1'b1;
                if (w_rvalid) w_next = S_DONE;
            end
            S_W: begin
                bus.bus_req          = 1'b1;
                bus.m_awvalid[r_sel] = !r_aw_done;
                bus.m_wvalid[r_sel]  = !r_w_done;
                if ((r_aw_done || w_awready) && (r_w_done || w_wready)) w_next = S_B;
            end
            S_B: begin
                bus.bus_req  = 1'b1;
                bus.m_bready = 1'b1;
                if (w_bvalid) w_next = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.m_araddr = r_addr;
    assign bus.m_awaddr = r_addr;
    assign bus.m_wdata  = w_wlane;
    assign bus.m_wstrb  = w_wstrb;
    assign bus.rdata    = r_rdata;
    assign bus.fault    = r_fault;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= 2'b00;
            r_sext    <= 1'b0;
            r_is_load <= 1'b0;
            r_sel     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_fault   <= 2'b00;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_addr    <= bus.addr;
                    r_wdata   <= bus.wdata;
                    r_size    <= bus.size;
                    r_sext    <= bus.sign_ext;
                    r_is_load <= bus.mem_read;
                    r_sel     <= w_hit_idx;
                    r_rdata   <= '0;
                    r_fault   <= w_misal ? 2'b01 : (!w_hit ? 2'b11 : 2'b00);
                end
                S_REQ: begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
                S_R: if (w_rvalid) begin
                    r_fault <= w_rresp[1] ? 2'b10 : 2'b00;
                    r_rdata <= w_rresp[1] ? '0 : w_load;
                end
                S_W: begin
                    if (w_awready) r_aw_done <= 1'b1;
                    if (w_wready)  r_w_done  <= 1'b1;
                end
                S_B: if (w_bvalid) r_fault <= w_bresp[1] ? 2'b10 : 2'b00;
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060184_lsu_axi.sv
// ============================================================================
// Module  : tb_ysyx_23060184_lsu_axi
// Brief   : Directed + randomized bench for the LSU against a spec-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060184_lsu_axi;
    localparam int NS = 2;
    localparam logic [NS*32-1:0] BASE = {32'ha000_0000, 32'h8000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hffff_f000, 32'hf800_0000};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060184_lsu_axi_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLV(NS)) bus ();

    ysyx_23060184_lsu_axi #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLV(NS), .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Slave/arbiter behaviour knobs
    int          grant_wait = 0, ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [1:0]  rresp_k = 2'b00, bresp_k = 2'b00;
    logic [31:0] mem_word = '0;
    int          tgt = 0;
    bit          stray = 1'b0;

    int g_c, ar_c, r_c, aw_c, w_c, b_c;
    logic [NS-1:0]    v_tmp;
    logic [NS*32-1:0] d_tmp;
    logic [NS*2-1:0]  s_tmp;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.bus_grant = 1'b0;
            bus.m_arready = '0; bus.m_rvalid = '0; bus.m_rdata = '0; bus.m_rresp = '0;
            bus.m_awready = '0; bus.m_wready = '0; bus.m_bvalid = '0; bus.m_bresp = '0;
            g_c = 0; ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        end else begin
            #1;
            g_c  = bus.bus_req          ? g_c + 1  : 0;
            ar_c = bus.m_arvalid[tgt]   ? ar_c + 1 : 0;
            r_c  = bus.m_rready         ? r_c + 1  : 0;
            aw_c = bus.m_awvalid[tgt]   ? aw_c + 1 : 0;
            w_c  = bus.m_wvalid[tgt]    ? w_c + 1  : 0;
            b_c  = bus.m_bready         ? b_c + 1  : 0;
            bus.bus_grant = bus.bus_req && (g_c > grant_wait);
            v_tmp = '0; v_tmp[tgt] = bus.m_arvalid[tgt] && (ar_c > ar_wait); bus.m_arready = v_tmp;
            v_tmp = '0; v_tmp[tgt] = bus.m_awvalid[tgt] && (aw_c > aw_wait); bus.m_awready = v_tmp;
            v_tmp = '0; v_tmp[tgt] = bus.m_wvalid[tgt]  && (w_c > w_wait);   bus.m_wready  = v_tmp;
            v_tmp = stray ? NS'($urandom) : '0;
            v_tmp[tgt] = bus.m_rready && (r_c > r_wait);
            bus.m_rvalid = v_tmp;
            v_tmp = stray ? NS'($urandom) : '0;
            v_tmp[tgt] = bus.m_bready && (b_c > b_wait);
            bus.m_bvalid = v_tmp;
            d_tmp = {$urandom, $urandom}; d_tmp[tgt*32 +: 32] = mem_word; bus.m_rdata = d_tmp;
            s_tmp = NS*2'($urandom); s_tmp[tgt*2 +: 2] = rresp_k; bus.m_rresp = s_tmp;
            s_tmp = NS*2'($urandom); s_tmp[tgt*2 +: 2] = bresp_k; bus.m_bresp = s_tmp;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
        return -1;
    endfunction

    function automatic bit model_misal(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        return (int'(a[1:0]) % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input bit sx);
        logic [31:0] v;
        if (sz == 2'b10) return w;
        if (sz == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hff;
            if (sx && v[7]) v = v | 32'hffff_ff00;
        end else begin
            v = (w >> (16 * a[1])) & 32'hffff;
            if (sx && v[15]) v = v | 32'hffff_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_strb(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b10) return 32'hf;
        return ((32'd1 << (1 << sz)) - 1) << a[1:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'b00) return d[7:0] * 32'h0101_0101;
        if (sz == 2'b01) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    // Issue one op, wait for its result, compare against the model, then retire it.
    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input bit sx,
                          input int hold, input int exp_lat);
        int sel, lat, nb;
        bit misal, is_load, done, saw_req, bus_used;
        logic [1:0]  ef;
        logic [31:0] er, wstrb_s, wdata_s;
        logic [NS-1:0] arb, awb, wb;
        misal   = model_misal(a, sz);
        sel     = model_sel(a);
        is_load = rd;
        bus_used = !misal && (sel >= 0);
        if (misal)           ef = 2'b01;
        else if (sel < 0)    ef = 2'b11;
        else if (is_load)    ef = rresp_k[1] ? 2'b10 : 2'b00;
        else                 ef = bresp_k[1] ? 2'b10 : 2'b00;
        er = (is_load && ef == 2'b00) ? model_load(mem_word, a, sz, sx) : 32'h0;

        @(negedge clk);
        tgt = (sel >= 0) ? sel : 0;
        bus.in_valid = 1'b1; bus.mem_read = rd; bus.mem_write = wr;
        bus.addr = a; bus.wdata = wd; bus.size = sz; bus.sign_ext = sx;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        lat = 0; done = 0; nb = 0; saw_req = 0; arb = '0; awb = '0; wb = '0;
        wstrb_s = '0; wdata_s = '0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.in_valid = 1'b0;
            saw_req = saw_req | bus.bus_req;
            arb = arb | bus.m_arvalid;
            awb = awb | bus.m_awvalid;
            wb  = wb  | bus.m_wvalid;
            if (|bus.m_wvalid) begin wstrb_s = 32'(bus.m_wstrb); wdata_s = bus.m_wdata; end
            if (bus.m_bready && bus.m_bvalid[tgt]) nb++;
            if (bus.out_valid) done = 1;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        if (exp_lat > 0) chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, bus.rdata, er);
        chk({tag, ".fault"}, 32'(bus.fault), 32'(ef));
        chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        if (!bus_used) begin
            chk({tag, ".no_req"}, 32'(saw_req), 32'd0);
            chk({tag, ".no_bus"}, 32'({arb, awb, wb}), 32'd0);
        end else if (is_load) begin
            chk({tag, ".arvalid_sel"}, 32'(arb), 32'd1 << tgt);
        end else begin
            chk({tag, ".awvalid_sel"}, 32'(awb), 32'd1 << tgt);
            chk({tag, ".wvalid_sel"}, 32'(wb), 32'd1 << tgt);
            chk({tag, ".wstrb"}, wstrb_s, model_strb(a, sz));
            chk({tag, ".wdata"}, wdata_s, model_wdata(wd, sz));
            chk({tag, ".b_count"}, 32'(nb), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_rdata"}, bus.rdata, er);
            chk({tag, ".hold_fault"}, 32'(bus.fault), 32'(ef));
            chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".retire_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".retire_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic set_waits(input int g, input int ar, input int r, input int aw,
                             input int w, input int b);
        grant_wait = g; ar_wait = ar; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b;
    endtask

    initial begin
        logic [31:0] ra, rwd;
        logic [1:0]  rsz;
        int          rop, rreg, k;

        bus.in_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr = '0;
        bus.wdata = '0; bus.size = 2'b00; bus.sign_ext = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.bus_req", 32'(bus.bus_req), 32'd0);
        chk("reset.valids", 32'({bus.m_arvalid, bus.m_awvalid, bus.m_wvalid}), 32'd0);
        chk("reset.readies", 32'({bus.m_rready, bus.m_bready}), 32'd0);
        chk("reset.rdata", bus.rdata, 32'd0);
        chk("reset.fault", 32'(bus.fault), 32'd0);
        rstn = 1'b1;

        // in_valid with no op selected is ignored
        @(negedge clk);
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("noop.in_ready", 32'(bus.in_ready), 32'd1);
        chk("noop.bus_req", 32'(bus.bus_req), 32'd0);
        chk("noop.out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;

        set_waits(0, 0, 0, 0, 0, 0);
        mem_word = 32'hA1B2_C3D4;
        run_op("lbu", 1, 0, 32'h8000_0003, 0, 2'b00, 0, 0, 4);
        mem_word = 32'h8001_1234;
        run_op("lh", 1, 0, 32'h8000_0002, 0, 2'b01, 1, 0, 4);
        run_op("lhu", 1, 0, 32'h8000_0002, 0, 2'b01, 0, 0, 4);
        run_op("sw_min", 0, 1, 32'h8000_0100, 32'hDEAD_BEEF, 2'b10, 0, 0, 4);

        set_waits(0, 0, 0, 0, 3, 0);
        run_op("sb_uart", 0, 1, 32'ha000_03f8, 32'h0000_005A, 2'b00, 0, 0, -1);

        set_waits(0, 0, 0, 0, 0, 0);
        run_op("lw_misal", 1, 0, 32'h8000_0002, 0, 2'b10, 0, 0, 1);
        run_op("lw_decerr", 1, 0, 32'h1000_0000, 0, 2'b10, 0, 0, 1);

        set_waits(5, 2, 0, 0, 0, 0);
        rresp_k = 2'b10;
        mem_word = 32'h1234_5678;
        run_op("lw_slverr", 1, 0, 32'h8000_0040, 0, 2'b10, 0, 3, -1);
        rresp_k = 2'b00;

        stray = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rreg = $urandom_range(0, 9);
            if (rreg < 5)      ra = 32'h8000_0000 | ($urandom & 32'h07ff_ffff);
            else if (rreg < 8) ra = 32'ha000_0000 | 32'($urandom_range(0, 4095));
            else               ra = $urandom;
            rsz = 2'($urandom_range(0, 3));
            rwd = $urandom;
            rop = $urandom_range(0, 2);
            mem_word = $urandom;
            rresp_k = 2'($urandom);
            bresp_k = 2'($urandom);
            set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            run_op("rand", rop != 1, rop != 0, ra, rwd, rsz, 1'($urandom), $urandom_range(0, 2), -1);
        end
        stray = 1'b0;
        rresp_k = 2'b00; bresp_k = 2'b00;

        // Reset while the load sits in R waiting for rvalid
        set_waits(0, 0, 20, 0, 0, 0);
        mem_word = 32'hCAFE_F00D;
        @(negedge clk);
        tgt = 0;
        bus.in_valid = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.addr = 32'h8000_0010; bus.size = 2'b10; bus.sign_ext = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.m_rready && k < 20) begin @(negedge clk); k++; end
        chk("rst_mid.reached_r", 32'(bus.m_rready), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid.bus_req", 32'(bus.bus_req), 32'd0);
        chk("rst_mid.rready", 32'(bus.m_rready), 32'd0);
        chk("rst_mid.valids", 32'({bus.m_arvalid, bus.m_awvalid, bus.m_wvalid}), 32'd0);
        chk("rst_mid.rdata", bus.rdata, 32'd0);
        chk("rst_mid.fault", 32'(bus.fault), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid.no_complete", 32'(bus.out_valid), 32'd0);
        rstn = 1'b1;
        set_waits(0, 0, 0, 0, 0, 0);
        run_op("lw_after_rst", 1, 0, 32'h8000_0010, 0, 2'b10, 0, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ysyx_23060184_lsu_axi.md
Name: ysyx_23060184_lsu_axi

Overview:
Parametrised load/store unit for the execute-to-writeback path. It accepts one memory op per handshake from EXU and arbitrates for the shared bus via req/grant. It decodes the address across NUM_SLV AXI4-Lite slaves (SRAM, UART, CLINT, ...) and runs the read or write transaction. It returns sign- or zero-extended load data, or store completion, plus an access-fault code to WBU. It generalises the fixed SRAM/UART memory stage to N slaves, byte/half/word sizing, misalignment detection and decode-error reporting.

Parameters:
DATA_WIDTH, 32, data bus width; fixed at 32 (byte lanes 4)
ADDR_WIDTH, 32, address width
NUM_SLV, 2, number of downstream slaves (1..8)
SLV_BASE, {32'ha000_0000,32'h8000_0000}, packed NUM_SLV*ADDR_WIDTH base addresses; slave i in bits [i*ADDR_WIDTH+:ADDR_WIDTH]
SLV_MASK, {32'hffff_fff0,32'hf800_0000}, packed match masks; hit_i = ((addr & MASK_i) == BASE_i)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  EXU op valid (Evalid)
in_ready  out  1  LSU can accept op (Mready)
mem_read  in  1  load op
mem_write  in  1  store op; mem_read&mem_write is illegal, treated as load
addr  in  ADDR_WIDTH  effective address (ALU result)
wdata  in  DATA_WIDTH  store data, low-aligned
size  in  2  00 byte, 01 half, 10 word; 11 -> misaligned fault
sign_ext  in  1  sign-extend load result
out_valid  out  1  result valid to WBU (Mvalid)
out_ready  in  1  WBU accepts (Wready)
rdata  out  DATA_WIDTH  extended load data; 0 for stores/faults
fault  out  2  00 OK, 01 misaligned, 10 slave error (SLVERR), 11 decode error
bus_req  out  1  arbiter request (Drequst)
bus_grant  in  1  arbiter grant for this master
m_araddr  out  ADDR_WIDTH  shared read address to all slaves
m_arvalid  out  NUM_SLV  one-hot per-slave arvalid
m_arready  in  NUM_SLV  per-slave arready
m_rdata  in  NUM_SLV*DATA_WIDTH  packed read data
m_rresp  in  NUM_SLV*2  packed read response
m_rvalid  in  NUM_SLV  per-slave rvalid
m_rready  out  1  shared rready; only selected slave's rvalid is honoured
m_awaddr  out  ADDR_WIDTH  write address
m_awvalid  out  NUM_SLV  one-hot
m_awready  in  NUM_SLV
m_wdata  out  DATA_WIDTH  lane-shifted store data
m_wstrb  out  4  byte strobes
m_wvalid  out  NUM_SLV  one-hot
m_wready  in  NUM_SLV
m_bresp  in  NUM_SLV*2
m_bvalid  in  NUM_SLV
m_bready  out  1  shared

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, in_ready=1, out_valid=0, bus_req=0, all *valid=0, m_rready=0, m_bready=0, rdata=0, fault=00, captured regs 0. Reset mid-transaction abandons it silently; no output completes.
- Accept on in_valid&in_ready with mem_read|mem_write. Capture addr, wdata, size, sign_ext, op and slave index sel (lowest hit). in_ready drops next cycle. in_valid with neither op is ignored.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Fault 01 goes straight to DONE. No bus_req.
- No slave hit: fault 11, straight to DONE, no bus_req.
- States: IDLE -> REQ (bus_req=1, wait bus_grant) -> AR (arvalid[sel]=1 until arready[sel]) -> R (rready=1 until rvalid[sel]) -> DONE; or REQ -> W (awvalid[sel] and wvalid[sel] asserted together; each drops independently on its own ready; leave when both done) -> B (bready=1 until bvalid[sel]) -> DONE.
- bus_req holds from REQ until the cycle R/B completes; it is deasserted in DONE. Grant loss mid-transaction is not permitted by the arbiter and need not be handled.
- A ready arriving in the same cycle valid rises completes that channel (zero wait). Minimum load latency is accept -> out_valid = 4 cycles with grant and all readies high. Store minimum is also 4 cycles.
- Write lanes: m_wstrb = byte 4'b0001<<a, half 4'b0011<<a, word 4'b1111, with a=addr[1:0]. m_wdata = wdata replicated per size (byte x4, half x2).
- Load extract: byte = rdata[8a+:8], half = rdata[16*a[1]+:16]; extend to 32 per sign_ext; word passes through.
- Response: resp[1]=1 -> fault 10 (SLVERR/DECERR from slave both map to 10), rdata=0. EXOKAY/OKAY -> fault 00.
- DONE: out_valid=1, rdata/fault held stable until out_ready. On out_valid&out_ready go to IDLE and set in_ready=1 the next cycle; there is no bypass accept in the DONE cycle.
- Only selected-slave signals are sampled; stray rvalid/bvalid from other slaves are ignored.

Test Plan:
- lbu at 0x8000_0003, SRAM word 0xA1B2C3D4, grant immediate, zero-wait -> out_valid 4 cycles after accept, rdata=0x000000A1, fault=00.
- lh sign at 0x8000_0002, word 0x8001_1234 -> rdata=0xFFFF8001. lhu -> 0x00008001.
- sb 0x5A to UART 0xa000_03f8 -> awvalid[1]&wvalid[1] only, m_wstrb=0001, m_wdata=0x5A5A5A5A. awready arrives 3 cycles before wready -> single B, fault=00.
- lw at 0x8000_0002 -> fault=01, no bus_req, out_valid 1 cycle after accept. lw at 0x1000_0000 -> fault=11, no bus activity.
- Load with grant delayed 5 cycles, arready 2-cycle wait, rresp=2'b10 -> fault=10, rdata=0. out_ready held low 3 cycles: outputs stable, in_ready=0.
- Assert rstn low during R state -> all outputs return to reset values immediately. A new lw after release completes normally.
